fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Instruction-fetch and field-decode stage that sits directly upstream of the control-flow decoder.
- Owns the program counter, addresses the synchronous instruction memory (1-cycle read latency) and holds the fetched word in an instruction register.
- Splits the instruction register into the opcode/register/ALU-op/immediate fields consumed by control, ALU and regfile.
- Computes the next PC for sequential flow, bne, blt, j, jal, jr and bex, and honours a stall from multi-cycle units.

Parameters:
- PC_WIDTH, 12, width of the PC and the imem address; all PC arithmetic wraps modulo 2^PC_WIDTH.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  PC_WIDTH  instruction memory address; equals pc at all times.
- imem_q  in  32  instruction memory read data, valid one cycle after the address is sampled.
- stall  in  1  hold the current instruction in EXEC (multdiv busy).
- is_not_equal  in  1  ALU compare result, $rd != $rs.
- is_less_than  in  1  ALU compare result, $rd < $rs.
- jr_target  in  32  regfile value of $rd, used by jr.
- r30_nonzero  in  1  $r30 != 0, used by bex.
- insn_valid  out  1  decoded fields are valid this cycle (high only in EXEC).
- opcode  out  5  IR[31:27].
- Rd  out  5  IR[26:22].
- Rs  out  5  IR[21:17].
- Rt  out  5  IR[16:12].
- shamt  out  5  IR[11:7].
- ALUopcode  out  5  IR[6:2].
- imm_sext  out  32  IR[16:0] sign-extended from bit 16.
- target  out  27  IR[26:0].
- pc_plus1  out  PC_WIDTH  pc+1 (wrapped); link value for jal.

Behaviour:
- Reset (reset low, asynchronous):
  - pc=RESET_PC, IR=0, state=FETCH, insn_valid=0.
  - All field outputs are 0 because they derive from IR.
  - Reset asserted mid-instruction abandons that instruction; no PC update occurs.
- State machine: FETCH -> WAIT -> EXEC -> FETCH.
  - FETCH: imem_addr=pc; ROM samples the address on this edge. Next state is WAIT unconditionally.
  - WAIT: imem_q is valid; IR <= imem_q at the end of the cycle. Next state is EXEC.
  - EXEC: insn_valid=1; fields are driven from IR.
    - If stall=1: remain in EXEC; pc and IR hold; insn_valid stays 1.
    - If stall=0: pc <= next_pc; next state is FETCH.
- Unstalled throughput is one instruction per 3 cycles.
- next_pc is evaluated in EXEC using that cycle's compare inputs. First match wins, in this order:
  - opcode 00010 (bne) and is_not_equal=1: pc+1+imm_sext.
  - opcode 00110 (blt) and is_less_than=1: pc+1+imm_sext.
  - opcode 00001 (j) or 00011 (jal): target[PC_WIDTH-1:0].
  - opcode 00100 (jr): jr_target[PC_WIDTH-1:0].
  - opcode 10110 (bex) and r30_nonzero=1: target[PC_WIDTH-1:0].
  - Otherwise, including an untaken bne/blt/bex: pc+1.
- Arithmetic is 32-bit, truncated to PC_WIDTH; a negative offset wraps.
  - pc=0, imm=-1 -> next_pc=0.
  - pc=2^PC_WIDTH-1, sequential -> next_pc=0.
- Stall asserted in FETCH or WAIT is ignored; it takes effect only in EXEC.
- Stall deasserting in EXEC: the PC updates on that same edge, using that cycle's compare inputs.
- Compare inputs and jr_target must be stable during the EXEC cycle in which stall=0. They are not registered by this block.
- pc_plus1 is combinational from pc and valid in every state.

Decomposition:
- Shared package:
  - Opcode constants: OP_RTYPE 00000, OP_J 00001, OP_BNE 00010, OP_JAL 00011, OP_JR 00100, OP_ADDI 00101, OP_BLT 00110, OP_SW 00111, OP_LW 01000, OP_SETX 10101, OP_BEX 10110.
  - Field bit-position constants.
  - Fetch state encoding: FETCH, WAIT, EXEC.
- One sub-module, next_pc_calc: purely combinational priority/adder logic.
- PC, IR and the FSM stay in the top module.

Test Plan:
- Reset released, imem holds an addi at 0 and 1 -> imem_addr 0,0,0,1; insn_valid pulses in cycles 3 and 6; opcode=00101; imm_sext of 0x1FFFF = 0xFFFFFFFF.
- bne at pc=5, imm=+3, is_not_equal=1 -> next imem_addr=9.
- Repeat with is_not_equal=0 -> next imem_addr=6.
- jal target=0x0000ABC at pc=7 -> pc_plus1=8 during EXEC; next imem_addr=0xABC.
- jr with jr_target=0xFFFF1234 -> next imem_addr=0x234.
- stall held 4 cycles in EXEC of an R-type -> insn_valid high for 5 cycles; IR and pc unchanged; then imem_addr=pc+1.
- reset pulsed low during WAIT at pc=0x10 -> pc=0, insn_valid=0 immediately; restart fetch at address 0.
- pc=0xFFF, sequential instruction -> imem_addr wraps to 0x000.
- bex with r30_nonzero=0 -> pc+1.
- bex with r30_nonzero=1 -> target.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: opcode values, instruction
// field bit positions, the fetch state encoding and an immediate helper.
package fetch_decode_stage_pkg;

  // Opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // Instruction field bit positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_MSB     = 26;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_MSB     = 21;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_MSB     = 16;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned SHAMT_MSB  = 11;
  localparam int unsigned SHAMT_LSB  = 7;
  localparam int unsigned ALUOP_MSB  = 6;
  localparam int unsigned ALUOP_LSB  = 2;
  localparam int unsigned IMM_MSB    = 16;
  localparam int unsigned TARGET_MSB = 26;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StExec  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sext_imm(input logic [IMM_MSB:0] imm);
    return {{(31 - IMM_MSB){imm[IMM_MSB]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_decode_stage_next_pc_calc.sv
// Next-PC selection for the fetch/decode stage. Purely combinational.
// Ports:
//   i_pc            current PC
//   i_opcode        decoded opcode
//   i_imm_sext      sign-extended immediate (branch offset)
//   i_target        jump target field
//   i_is_not_equal  bne condition
//   i_is_less_than  blt condition
//   i_jr_target     register value for jr
//   i_r30_nonzero   bex condition
//   o_next_pc       PC to load when the current instruction retires
module fetch_decode_stage_next_pc_calc
  import fetch_decode_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 12
) (
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic [4:0]          i_opcode,
  input  logic [31:0]         i_imm_sext,
  input  logic [26:0]         i_target,
  input  logic                i_is_not_equal,
  input  logic                i_is_less_than,
  input  logic [31:0]         i_jr_target,
  input  logic                i_r30_nonzero,
  output logic [PC_WIDTH-1:0] o_next_pc
);

  // Offsets are added at 32 bits and truncated, so negative offsets wrap.
  logic [31:0] w_seq;
  logic [31:0] w_branch;

  assign w_seq    = 32'(i_pc) + 32'd1;
  assign w_branch = w_seq + i_imm_sext;

  // First match wins; untaken conditionals fall through to pc+1.
  always_comb begin
    o_next_pc = w_seq[PC_WIDTH-1:0];
    if (i_opcode == OP_BNE && i_is_not_equal) begin
      o_next_pc = w_branch[PC_WIDTH-1:0];
    end else if (i_opcode == OP_BLT && i_is_less_than) begin
      o_next_pc = w_branch[PC_WIDTH-1:0];
    end else if (i_opcode == OP_J || i_opcode == OP_JAL) begin
      o_next_pc = i_target[PC_WIDTH-1:0];
    end else if (i_opcode == OP_JR) begin
      o_next_pc = i_jr_target[PC_WIDTH-1:0];
    end else if (i_opcode == OP_BEX && i_r30_nonzero) begin
      o_next_pc = i_target[PC_WIDTH-1:0];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{w_seq[31:PC_WIDTH], w_branch[31:PC_WIDTH],
                         i_jr_target[31:PC_WIDTH], i_target[26:PC_WIDTH]};

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch and field decode stage. Owns the PC and instruction
// register, sequences FETCH -> WAIT -> EXEC against a 1-cycle synchronous
// instruction memory, and presents decoded fields during EXEC.
// Ports:
//   i_clock, i_reset        clock, asynchronous active-low reset
//   o_imem_addr / i_imem_q  instruction memory address / read data
//   i_stall                 hold the instruction in EXEC
//   i_is_not_equal, i_is_less_than, i_jr_target, i_r30_nonzero
//                           control-flow inputs, sampled in EXEC
//   o_insn_valid            decoded fields valid (EXEC only)
//   o_opcode .. o_target    instruction fields
//   o_pc_plus1              pc+1, link value for jal
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic [31:0]         i_imem_q,
  input  logic                i_stall,
  input  logic                i_is_not_equal,
  input  logic                i_is_less_than,
  input  logic [31:0]         i_jr_target,
  input  logic                i_r30_nonzero,
  output logic                o_insn_valid,
  output logic [4:0]          o_opcode,
  output logic [4:0]          o_rd,
  output logic [4:0]          o_rs,
  output logic [4:0]          o_rt,
  output logic [4:0]          o_shamt,
  output logic [4:0]          o_alu_opcode,
  output logic [31:0]         o_imm_sext,
  output logic [26:0]         o_target,
  output logic [PC_WIDTH-1:0] o_pc_plus1
);

  fetch_state_e        r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_ir;
  logic                r_insn_valid;
  logic [PC_WIDTH-1:0] w_next_pc;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StFetch;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_insn_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StFetch: r_state <= StWait;
        StWait: begin
          r_ir         <= i_imem_q;
          r_insn_valid <= 1'b1;
          r_state      <= StExec;
        end
        StExec: begin
          // Stall only matters here; the PC moves on the edge stall drops.
          if (!i_stall) begin
            r_pc         <= w_next_pc;
            r_insn_valid <= 1'b0;
            r_state      <= StFetch;
          end
        end
        default: r_state <= StFetch;
      endcase
    end
  end

  fetch_decode_stage_next_pc_calc #(
    .PC_WIDTH(PC_WIDTH)
  ) u_next_pc_calc (
    .i_pc           (r_pc),
    .i_opcode       (o_opcode),
    .i_imm_sext     (o_imm_sext),
    .i_target       (o_target),
    .i_is_not_equal (i_is_not_equal),
    .i_is_less_than (i_is_less_than),
    .i_jr_target    (i_jr_target),
    .i_r30_nonzero  (i_r30_nonzero),
    .o_next_pc      (w_next_pc)
  );

  assign o_imem_addr  = r_pc;
  assign o_pc_plus1   = r_pc + PC_WIDTH'(1);
  assign o_insn_valid = r_insn_valid;
  assign o_opcode     = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign o_rd         = r_ir[RD_MSB:RD_LSB];
  assign o_rs         = r_ir[RS_MSB:RS_LSB];
  assign o_rt         = r_ir[RT_MSB:RT_LSB];
  assign o_shamt      = r_ir[SHAMT_MSB:SHAMT_LSB];
  assign o_alu_opcode = r_ir[ALUOP_MSB:ALUOP_LSB];
  assign o_imm_sext   = sext_imm(r_ir[IMM_MSB:0]);
  assign o_target     = r_ir[TARGET_MSB:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: the stimulus process steps through
// a directed program and pushes the expected EXEC view of each instruction;
// a monitor pops and checks whenever the DUT presents a valid instruction.
module tb_fetch_decode_stage;

  logic        clk;
  logic        rst;
  logic [11:0] imem_addr;
  logic [31:0] imem_q;
  logic        stall;
  logic        is_ne;
  logic        is_lt;
  logic [31:0] jr_target;
  logic        r30_nz;
  logic        insn_valid;
  logic [4:0]  opcode, rd, rs, rt, shamt, alu_op;
  logic [31:0] imm_sext;
  logic [26:0] target;
  logic [11:0] pc_plus1;

  logic [31:0] mem [4096];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  op, rd, rs, rt, sh, alu;
    logic [31:0] imm;
    logic [26:0] tgt;
    logic [11:0] pc, plus1, nxt;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];

  fetch_decode_stage #(
    .PC_WIDTH(12),
    .RESET_PC(12'h000)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .o_imem_addr    (imem_addr),
    .i_imem_q       (imem_q),
    .i_stall        (stall),
    .i_is_not_equal (is_ne),
    .i_is_less_than (is_lt),
    .i_jr_target    (jr_target),
    .i_r30_nonzero  (r30_nz),
    .o_insn_valid   (insn_valid),
    .o_opcode       (opcode),
    .o_rd           (rd),
    .o_rs           (rs),
    .o_rt           (rt),
    .o_shamt        (shamt),
    .o_alu_opcode   (alu_op),
    .o_imm_sext     (imm_sext),
    .o_target       (target),
    .o_pc_plus1     (pc_plus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) imem_q <= mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] r_d,
                                        input logic [4:0] r_s, input logic [16:0] imm);
    return {op, r_d, r_s, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] tgt);
    return {op, tgt};
  endfunction

  function automatic exp_t mk(input logic [4:0] op, input logic [4:0] r_d, input logic [4:0] r_s,
                              input logic [4:0] r_t, input logic [4:0] sh, input logic [4:0] alu,
                              input logic [31:0] imm, input logic [26:0] tgt,
                              input logic [11:0] pc, input logic [11:0] plus1,
                              input logic [11:0] nxt);
    exp_t e;
    e.op = op; e.rd = r_d; e.rs = r_s; e.rt = r_t; e.sh = sh; e.alu = alu;
    e.imm = imm; e.tgt = tgt; e.pc = pc; e.plus1 = plus1; e.nxt = nxt; e.cycles = 1;
    return e;
  endfunction

  // Entered #1 after a rising edge with the DUT in FETCH; leaves the same way.
  task automatic run_insn(input exp_t e, input logic ne, input logic lt, input logic r30,
                          input logic [31:0] jr, input int stalls);
    exp_t t;
    t = e;
    t.cycles = stalls + 1;
    exp_q.push_back(t);
    is_ne = ne; is_lt = lt; r30_nz = r30; jr_target = jr;
    stall = (stalls > 0);  // raised early on purpose: ignored outside EXEC
    repeat (2) begin @(posedge clk); #1; end
    repeat (stalls) begin @(posedge clk); #1; end
    stall = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor
  initial begin
    exp_t cur;
    bit   in_exec;
    int   gap;
    int   run;
    in_exec = 0; gap = 0; run = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_exec = 0;
        gap = 0;
      end else if (insn_valid) begin
        if (!in_exec) begin
          check("fetch_gap", 32'(gap), 32'd2);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_insn: valid at pc 0x%0h, expected none", imem_addr);
            cur = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'd0, 12'd0, 12'd0, 12'd0);
          end else begin
            cur = exp_q.pop_front();
          end
          in_exec = 1;
          run = 0;
        end
        run++;
        check("opcode", 32'(opcode), 32'(cur.op));
        check("rd", 32'(rd), 32'(cur.rd));
        check("rs", 32'(rs), 32'(cur.rs));
        check("rt", 32'(rt), 32'(cur.rt));
        check("shamt", 32'(shamt), 32'(cur.sh));
        check("alu_op", 32'(alu_op), 32'(cur.alu));
        check("imm_sext", imm_sext, cur.imm);
        check("target", 32'(target), 32'(cur.tgt));
        check("exec_pc", 32'(imem_addr), 32'(cur.pc));
        check("pc_plus1", 32'(pc_plus1), 32'(cur.plus1));
      end else begin
        if (in_exec) begin
          check("valid_cycles", 32'(run), 32'(cur.cycles));
          check("next_pc", 32'(imem_addr), 32'(cur.nxt));
          in_exec = 0;
          gap = 0;
        end
        gap++;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, %0d expectations left", exp_q.size());
    $fatal(1);
  end

  localparam logic [4:0] J = 5'b00001, BNE = 5'b00010, JAL = 5'b00011, JR = 5'b00100;
  localparam logic [4:0] ADDI = 5'b00101, BLT = 5'b00110, BEX = 5'b10110;

  initial begin
    exp_t a0, a1, j5_2, j5_9, bne_t, bne_n, blt_n, blt_t;

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h000] = enc_i(ADDI, 5'd1, 5'd0, 17'h1FFFF);
    mem[12'h001] = enc_i(ADDI, 5'd2, 5'd1, 17'h00004);
    mem[12'h002] = enc_j(J, 27'd5);
    mem[12'h005] = enc_i(BNE, 5'd1, 5'd2, 17'd3);
    mem[12'h006] = enc_i(BLT, 5'd1, 5'd2, 17'd9);
    mem[12'h007] = enc_j(JAL, 27'hABC);
    mem[12'h009] = enc_j(J, 27'd5);
    mem[12'h010] = enc_j(BEX, 27'hFFF);
    mem[12'hABC] = enc_i(BLT, 5'd3, 5'd4, 17'h1FFFD);
    mem[12'hABA] = enc_i(JR, 5'd5, 5'd0, 17'd0);
    mem[12'h235] = enc_j(BEX, 27'h100);
    mem[12'h236] = enc_j(BEX, 27'hFFF);

    a0    = mk(5'd5, 5'd1, 5'd0, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 27'h041FFFF,
               12'h000, 12'h001, 12'h001);
    a1    = mk(5'd5, 5'd2, 5'd1, 5'd0, 5'd0, 5'd1, 32'h4, 27'h0820004,
               12'h001, 12'h002, 12'h002);
    j5_2  = mk(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 32'h5, 27'h5, 12'h002, 12'h003, 12'h005);
    j5_9  = mk(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 32'h5, 27'h5, 12'h009, 12'h00A, 12'h005);
    bne_t = mk(5'd2, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'h3, 27'h0440003,
               12'h005, 12'h006, 12'h009);
    bne_n = mk(5'd2, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'h3, 27'h0440003,
               12'h005, 12'h006, 12'h006);
    blt_n = mk(5'd6, 5'd1, 5'd2, 5'd0, 5'd0, 5'd2, 32'h9, 27'h0440009,
               12'h006, 12'h007, 12'h007);
    blt_t = mk(5'd6, 5'd1, 5'd2, 5'd0, 5'd0, 5'd2, 32'h9, 27'h0440009,
               12'h006, 12'h007, 12'h010);

    rst = 1'b0; stall = 1'b0; is_ne = 1'b0; is_lt = 1'b0; jr_target = 32'h0; r30_nz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(insn_valid), 32'd0);
    check("reset_addr", 32'(imem_addr), 32'h000);
    check("reset_opcode", 32'(opcode), 32'd0);
    check("reset_imm", imm_sext, 32'd0);
    rst = 1'b1;

    run_insn(a0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(a1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(j5_2, 1'b1, 1'b1, 1'b1, 32'h0, 0);
    run_insn(bne_t, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    run_insn(j5_9, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(bne_n, 1'b0, 1'b1, 1'b0, 32'h0, 0);      // lt must not steer a bne
    run_insn(blt_n, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    run_insn(mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd21, 5'd15, 32'h00000ABC, 27'h0000ABC,
                12'h007, 12'h008, 12'hABC), 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(mk(5'd6, 5'd3, 5'd4, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFD, 27'h0C9FFFD,
                12'hABC, 12'hABD, 12'hABA), 1'b0, 1'b1, 1'b0, 32'h0, 0);
    run_insn(mk(5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 27'h1400000,
                12'hABA, 12'hABB, 12'h234), 1'b0, 1'b0, 1'b0, 32'hFFFF1234, 0);
    run_insn(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 27'h0,
                12'h234, 12'h235, 12'h235), 1'b0, 1'b0, 1'b0, 32'h0, 4);
    run_insn(mk(5'd22, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 32'h100, 27'h100,
                12'h235, 12'h236, 12'h236), 1'b1, 1'b1, 1'b0, 32'h0, 0);
    run_insn(mk(5'd22, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 32'hFFF, 27'hFFF,
                12'h236, 12'h237, 12'hFFF), 1'b0, 1'b0, 1'b1, 32'h0, 0);
    run_insn(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 27'h0,
                12'hFFF, 12'h000, 12'h000), 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(a0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(a1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(j5_2, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(bne_n, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_insn(blt_t, 1'b0, 1'b1, 1'b0, 32'h0, 0);

    // Now in FETCH at pc 0x10; move to WAIT, then pulse reset asynchronously.
    check("pc_before_reset", 32'(imem_addr), 32'h010);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midreset_valid", 32'(insn_valid), 32'd0);
    check("midreset_addr", 32'(imem_addr), 32'h000);
    check("midreset_opcode", 32'(opcode), 32'd0);
    check("midreset_target", 32'(target), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_insn(a0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
